// File: rtl/mem_arbiter.sv
// Two-requester (CPU, IO) arbiter in front of a single-port synchronous memory.
// Each access takes IDLE -> ACCESS -> DONE. The CPU wins contention until it has
// taken STARVE_MAX consecutive grants while IO waits; then IO is granted.
module mem_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int STARVE_MAX = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          io_req,
    input  logic          io_we,
    input  logic [AW-1:0] io_addr,
    input  logic [DW-1:0] io_wdata,
    output logic          io_ack,
    output logic [DW-1:0] io_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    typedef enum logic {OWN_CPU, OWN_IO} owner_t;

    state_t        state, state_nxt;
    owner_t        owner, grant_owner;
    logic          grant;
    logic [CW-1:0] starve_cnt, starve_nxt;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state, grant decision and starvation counter update
    always_comb begin
        state_nxt   = state;
        grant       = 1'b0;
        grant_owner = OWN_CPU;
        starve_nxt  = starve_cnt;
        case (state)
            IDLE: begin
                if (!io_req) starve_nxt = '0;
                if (cpu_req && io_req) begin
                    grant = 1'b1;
                    if (starve_cnt < STARVE_LIM) begin
                        grant_owner = OWN_CPU;
                        starve_nxt  = starve_cnt + 1'b1;
                    end else begin
                        grant_owner = OWN_IO;
                        starve_nxt  = '0;
                    end
                end else if (cpu_req) begin
                    grant       = 1'b1;
                    grant_owner = OWN_CPU;
                end else if (io_req) begin
                    grant       = 1'b1;
                    grant_owner = OWN_IO;
                    starve_nxt  = '0;
                end
                if (grant) state_nxt = ACCESS;
            end
            ACCESS:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: the mem_* registers double as the latched request, so mem_we
    // (high only in ACCESS) tells the ACCESS->DONE edge whether to capture rdata
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner      <= OWN_CPU;
            starve_cnt <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
            cpu_ack    <= 1'b0;
            io_ack     <= 1'b0;
            cpu_rdata  <= '0;
            io_rdata   <= '0;
        end else begin
            mem_we  <= 1'b0;
            cpu_ack <= 1'b0;
            io_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    starve_cnt <= starve_nxt;
                    if (grant) begin
                        owner <= grant_owner;
                        if (grant_owner == OWN_IO) begin
                            mem_addr  <= io_addr;
                            mem_wdata <= io_wdata;
                            mem_we    <= io_we;
                        end else begin
                            mem_addr  <= cpu_addr;
                            mem_wdata <= cpu_wdata;
                            mem_we    <= cpu_we;
                        end
                    end
                end
                ACCESS: begin
                    if (owner == OWN_IO) begin
                        io_ack <= 1'b1;
                        if (!mem_we) io_rdata <= mem_rdata;
                    end else begin
                        cpu_ack <= 1'b1;
                        if (!mem_we) cpu_rdata <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a scoreboard of expected completions
// (owner, read/write, read data) is filled as requests are driven and drained
// by a monitor on every ack.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, io_req, io_we;
    logic [15:0] cpu_addr, cpu_wdata, io_addr, io_wdata;
    logic        cpu_ack, io_ack, mem_we, busy;
    logic [15:0] cpu_rdata, io_rdata, mem_addr, mem_wdata, mem_rdata;

    logic [15:0] mem [0:65535];

    typedef struct packed {
        logic        io;
        logic        we;
        logic [15:0] rdata;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [15:0] exp_cpu_rd = '0;
    logic [15:0] exp_io_rd = '0;

    mem_arbiter #(.AW(16), .DW(16), .STARVE_MAX(2)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_ack(io_ack), .io_rdata(io_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: data for the presented address is available by the next edge
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    function automatic exp_t mk(input logic io, input logic we, input logic [15:0] rd);
        exp_t e;
        e.io = io; e.we = we; e.rdata = rd;
        return e;
    endfunction

    // Scoreboard monitor: every ack must match the next expected completion
    always @(negedge clk) begin
        exp_t e;
        if (cpu_ack || io_ack) begin
            checks++;
            if (cpu_ack && io_ack) begin
                errors++;
                $display("FAIL dual_ack cpu_ack=%b io_ack=%b required one", cpu_ack, io_ack);
            end else if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack cpu_ack=%b io_ack=%b at cycle %0d", cpu_ack, io_ack, cyc);
            end else begin
                e = q.pop_front();
                if (io_ack !== e.io) begin
                    errors++;
                    $display("FAIL grant_order got io=%b required io=%b at cycle %0d", io_ack, e.io, cyc);
                end else begin
                    checks++;
                    if (e.io) begin
                        if (!e.we) exp_io_rd = e.rdata;
                        if (io_rdata !== exp_io_rd) begin
                            errors++;
                            $display("FAIL io_rdata got %h required %h", io_rdata, exp_io_rd);
                        end
                    end else begin
                        if (!e.we) exp_cpu_rd = e.rdata;
                        if (cpu_rdata !== exp_cpu_rd) begin
                            errors++;
                            $display("FAIL cpu_rdata got %h required %h", cpu_rdata, exp_cpu_rd);
                        end
                    end
                end
            end
        end
    end

    // Wait for n acks (bounded); optionally drop both requests on the last ack
    task automatic wait_acks(input int n, input bit drop, output int last_cyc);
        int seen = 0;
        int budget = 0;
        last_cyc = 0;
        while (seen < n && budget < 200) begin
            @(negedge clk);
            budget++;
            if (cpu_ack || io_ack) begin
                seen++;
                last_cyc = cyc;
            end
        end
        checks++;
        if (seen < n) begin
            errors++;
            $display("FAIL ack_timeout got %0d acks required %0d", seen, n);
        end
        if (drop) begin
            cpu_req = 1'b0;
            io_req  = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        io_req = 0; io_we = 0; io_addr = '0; io_wdata = '0;
        @(negedge clk); @(negedge clk);
        checks++;
        if ({cpu_ack, io_ack, mem_we, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl got ack/ack/we/busy=%b required 0000", {cpu_ack, io_ack, mem_we, busy});
        end
        checks++;
        if (mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin
            errors++;
            $display("FAIL reset_mem got addr=%h wdata=%h required 0", mem_addr, mem_wdata);
        end
        checks++;
        if (cpu_rdata !== 16'h0 || io_rdata !== 16'h0) begin
            errors++;
            $display("FAIL reset_rdata got cpu=%h io=%h required 0", cpu_rdata, io_rdata);
        end
        reset = 1'b1;
    endtask

    task automatic test_cpu_read();
        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        q.push_back(mk(1'b0, 1'b0, 16'hBEEF));
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || mem_addr !== 16'h0010 || mem_we !== 1'b0 || cpu_ack !== 1'b0) begin
            errors++;
            $display("FAIL cpu_read_access got busy=%b addr=%h we=%b ack=%b required 1 0010 0 0",
                     busy, mem_addr, mem_we, cpu_ack);
        end
        @(negedge clk);
        checks++;
        if (cpu_ack !== 1'b1 || io_ack !== 1'b0) begin
            errors++;
            $display("FAIL cpu_read_latency got cpu_ack=%b io_ack=%b required 1 0", cpu_ack, io_ack);
        end
        cpu_req = 0;
        @(negedge clk);
        checks++;
        if (cpu_ack !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL cpu_ack_pulse got ack=%b busy=%b required 0 0", cpu_ack, busy);
        end
    endtask

    task automatic test_io_write();
        @(negedge clk);
        io_req = 1; io_we = 1; io_addr = 16'h0200; io_wdata = 16'h1234;
        q.push_back(mk(1'b1, 1'b1, 16'h0));
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 16'h0200 || mem_wdata !== 16'h1234 || io_ack !== 1'b0) begin
            errors++;
            $display("FAIL io_write_access got we=%b addr=%h wdata=%h ack=%b required 1 0200 1234 0",
                     mem_we, mem_addr, mem_wdata, io_ack);
        end
        // Inputs changing in flight must not disturb the access
        io_addr = 16'h0BAD; io_wdata = 16'hFFFF;
        @(negedge clk);
        checks++;
        if (io_ack !== 1'b1 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL io_write_done got ack=%b we=%b required 1 0", io_ack, mem_we);
        end
        io_req = 0;
        @(negedge clk);
        checks++;
        if (mem[16'h0200] !== 16'h1234 || mem[16'h0BAD] !== 16'h0) begin
            errors++;
            $display("FAIL io_write_mem got [0200]=%h [0BAD]=%h required 1234 0000",
                     mem[16'h0200], mem[16'h0BAD]);
        end
    endtask

    task automatic test_contention();
        int c;
        @(negedge clk);
        cpu_we = 0; cpu_addr = 16'h0010;
        io_we = 0; io_addr = 16'h0200;
        for (int unsigned i = 0; i < 2; i++) begin
            q.push_back(mk(1'b0, 1'b0, 16'hBEEF));
            q.push_back(mk(1'b0, 1'b0, 16'hBEEF));
            q.push_back(mk(1'b1, 1'b0, 16'h1234));
        end
        cpu_req = 1; io_req = 1;
        wait_acks(6, 1'b1, c);
    endtask

    task automatic test_starve_clear();
        int c;
        @(negedge clk);
        cpu_we = 0; cpu_addr = 16'h0011;
        io_we = 0; io_addr = 16'h0010;
        q.push_back(mk(1'b0, 1'b0, 16'hCAFE));
        cpu_req = 1; io_req = 1;
        wait_acks(1, 1'b1, c);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL starve_idle got busy=%b required 0", busy);
        end
        q.push_back(mk(1'b0, 1'b0, 16'hCAFE));
        q.push_back(mk(1'b0, 1'b0, 16'hCAFE));
        q.push_back(mk(1'b1, 1'b0, 16'hBEEF));
        cpu_req = 1; io_req = 1;
        wait_acks(3, 1'b1, c);
    endtask

    task automatic test_reset_mid_write();
        int c;
        @(negedge clk);
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0300; cpu_wdata = 16'h5555;
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_we got %b required 1", mem_we);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if (mem_we !== 1'b0 || busy !== 1'b0 || cpu_ack !== 1'b0 || mem_addr !== 16'h0) begin
            errors++;
            $display("FAIL rst_abort got we=%b busy=%b ack=%b addr=%h required 0 0 0 0000",
                     mem_we, busy, cpu_ack, mem_addr);
        end
        exp_cpu_rd = '0;
        exp_io_rd  = '0;
        @(negedge clk); @(negedge clk);
        checks++;
        if (cpu_ack !== 1'b0 || mem[16'h0300] !== 16'h0) begin
            errors++;
            $display("FAIL rst_no_write got ack=%b [0300]=%h required 0 0000", cpu_ack, mem[16'h0300]);
        end
        reset = 1'b1;
        q.push_back(mk(1'b0, 1'b1, 16'h0));
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 16'h0300 || mem_wdata !== 16'h5555) begin
            errors++;
            $display("FAIL rst_fresh_access got we=%b addr=%h wdata=%h required 1 0300 5555",
                     mem_we, mem_addr, mem_wdata);
        end
        wait_acks(1, 1'b1, c);
        checks++;
        if (mem[16'h0300] !== 16'h5555) begin
            errors++;
            $display("FAIL rst_fresh_mem got %h required 5555", mem[16'h0300]);
        end
    endtask

    task automatic test_back_to_back();
        int c1, c2;
        @(negedge clk);
        cpu_we = 0; cpu_addr = 16'h0010;
        q.push_back(mk(1'b0, 1'b0, 16'hBEEF));
        q.push_back(mk(1'b0, 1'b0, 16'hCAFE));
        cpu_req = 1;
        wait_acks(1, 1'b0, c1);
        cpu_addr = 16'h0011;
        wait_acks(1, 1'b1, c2);
        checks++;
        if (c2 - c1 !== 3) begin
            errors++;
            $display("FAIL back_to_back_spacing got %0d cycles required 3", c2 - c1);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0;
        mem[16'h0010] = 16'hBEEF;
        mem[16'h0011] = 16'hCAFE;
        test_reset();
        test_cpu_read();
        test_io_write();
        test_contention();
        test_starve_clear();
        test_reset_mid_write();
        test_back_to_back();
        repeat (4) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
